systolic_sequencer: RTL and testbench

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

---
 rtl/systolic_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_systolic_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_sequencer                                                 |
// | Sequences one matrix tile: clears the array, streams A/B operand   |
// | vectors from the buffers and skews each lane onto the array edges. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module systolic_sequencer #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           k_len,
  input  logic [1:0]                  simd_in,
  output logic                        a_rd_en,
  output logic [ADDR_W-1:0]           a_rd_addr,
  output logic                        b_rd_en,
  output logic [ADDR_W-1:0]           b_rd_addr,
  input  logic [ARR_HEIGHT*WIDTH-1:0] a_rd_data,
  input  logic [ARR_WIDTH*WIDTH-1:0]  b_rd_data,
  output logic [ARR_HEIGHT*WIDTH-1:0] arr_in_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  arr_in_b,
  output logic                        arr_clear,
  output logic [1:0]                  arr_simd,
  output logic                        busy,
  output logic                        done,
  output logic                        c_valid
);

  // Drain covers read latency, the longest skew path and the final accumulate.
  localparam logic [ADDR_W:0] c_drain_len = (ADDR_W+1)'(ARR_HEIGHT + ARR_WIDTH);
  localparam logic [ADDR_W:0] c_cnt_one   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] klen_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic              clear_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        simd_q;
  logic              vtag_q;
  logic              w_flush;

  assign w_flush = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      simd_q  <= 2'b00;
    end else if (w_flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      clear_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            busy_q <= 1'b1;
            simd_q <= simd_in;
            if (k_len != '0) begin
              klen_q  <= k_len;
              clear_q <= 1'b1;
              state_q <= S_CLEAR;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          state_q <= S_FEED;
          rd_en_q <= 1'b1;
          addr_q  <= '0;
          cnt_q   <= c_cnt_one;
        end
        S_FEED: begin
          // cnt_q counts reads already issued, so k_len never needs to wrap.
          if (cnt_q == {1'b0, klen_q}) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            cnt_q   <= c_cnt_one;
          end else begin
            addr_q <= cnt_q[ADDR_W-1:0];
            cnt_q  <= cnt_q + c_cnt_one;
          end
        end
        S_DRAIN: begin
          if (cnt_q == c_drain_len) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag marks the cycle in which rd_data holds a genuine operand vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vtag_q <= 1'b0;
    else       vtag_q <= rd_en_q && !w_flush;
  end

  generate
    for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_a_lane
      if (i == 0) begin : g_direct
        assign arr_in_a[WIDTH-1:0] = vtag_q ? a_rd_data[WIDTH-1:0] : '0;
      end else begin : g_skew
        logic [WIDTH:0] stage_q [i];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int s = 0; s < i; s++) stage_q[s] <= '0;
          end else begin
            stage_q[0] <= {vtag_q && !w_flush, a_rd_data[i*WIDTH +: WIDTH]};
            for (int s = 1; s < i; s++)
              stage_q[s] <= {stage_q[s-1][WIDTH] && !w_flush, stage_q[s-1][WIDTH-1:0]};
          end
        end
        assign arr_in_a[i*WIDTH +: WIDTH] = stage_q[i-1][WIDTH] ? stage_q[i-1][WIDTH-1:0] : '0;
      end
    end

    for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_b_lane
      if (j == 0) begin : g_direct
        assign arr_in_b[WIDTH-1:0] = vtag_q ? b_rd_data[WIDTH-1:0] : '0;
      end else begin : g_skew
        logic [WIDTH:0] stage_q [j];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int s = 0; s < j; s++) stage_q[s] <= '0;
          end else begin
            stage_q[0] <= {vtag_q && !w_flush, b_rd_data[j*WIDTH +: WIDTH]};
            for (int s = 1; s < j; s++)
              stage_q[s] <= {stage_q[s-1][WIDTH] && !w_flush, stage_q[s-1][WIDTH-1:0]};
          end
        end
        assign arr_in_b[j*WIDTH +: WIDTH] = stage_q[j-1][WIDTH] ? stage_q[j-1][WIDTH-1:0] : '0;
      end
    end
  endgenerate

  assign a_rd_en   = rd_en_q;
  assign b_rd_en   = rd_en_q;
  assign a_rd_addr = addr_q;
  assign b_rd_addr = addr_q;
  assign arr_clear = clear_q;
  assign arr_simd  = simd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign c_valid   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// tb_systolic_sequencer: randomized tiles compared cycle by cycle against a
// schedule model derived from the tile timing rules.
module tb_systolic_sequencer;
  localparam int WD = 16;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int AW = 8;
  localparam int DA = H*WD;
  localparam int DB = W*WD;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clear;
    logic          rd;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start, abort;
  logic [AW-1:0] k_len;
  logic [1:0]    simd_in;
  logic          a_rd_en, b_rd_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [DA-1:0] a_rd_data;
  logic [DB-1:0] b_rd_data;
  logic [DA-1:0] arr_in_a;
  logic [DB-1:0] arr_in_b;
  logic          arr_clear;
  logic [1:0]    arr_simd;
  logic          busy, done, c_valid;

  logic [DA-1:0] amem [256];
  logic [DB-1:0] bmem [256];
  int n_checks = 0;
  int n_pass   = 0;

  logic [2*AW+DA+DB+7:0] outs;
  assign outs = {a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_in_a, arr_in_b,
                 arr_clear, arr_simd, busy, done, c_valid};

  always #5 clk = ~clk;

  systolic_sequencer #(.WIDTH(WD), .ARR_HEIGHT(H), .ARR_WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_len(k_len),
    .simd_in(simd_in), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en),
    .b_rd_addr(b_rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .arr_in_a(arr_in_a), .arr_in_b(arr_in_b), .arr_clear(arr_clear),
    .arr_simd(arr_simd), .busy(busy), .done(done), .c_valid(c_valid)
  );

  // Operand buffers: one-cycle read latency, garbage on the bus when not read.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? amem[a_rd_addr] : {$urandom, $urandom};
    b_rd_data <= b_rd_en ? bmem[b_rd_addr] : {$urandom, $urandom};
  end

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      amem[i] = {$urandom, $urandom};
      bmem[i] = {$urandom, $urandom};
    end
  endtask

  // Cycle c counts from the edge that accepted start (c=1 is the first cycle after it).
  function automatic exp_t model_ctrl(int k, int ab, int c);
    exp_t e;
    int   last;
    e = '0;
    last = (k == 0) ? 1 : k + H + W + 2;
    if (ab > 0 && c > ab) begin
      e.clear = (c == ab + 1);
      return e;
    end
    e.busy = (c >= 1 && c <= last);
    e.done = (c == last);
    if (k > 0) begin
      e.clear = (c == 1);
      e.rd    = (c >= 2 && c <= k + 1);
      if (e.rd) e.addr = AW'(c - 2);
    end
    return e;
  endfunction

  // Vector m is read in cycle m+2, returns in m+3 and reaches lane i i cycles later.
  function automatic logic [DA-1:0] model_a(int k, int ab, int c);
    logic [DA-1:0] v;
    v = '0;
    if (ab > 0 && c > ab) return v;
    for (int i = 0; i < H; i++) begin
      int m;
      m = c - 3 - i;
      if (m >= 0 && m < k) v[i*WD +: WD] = amem[m][i*WD +: WD];
    end
    return v;
  endfunction

  function automatic logic [DB-1:0] model_b(int k, int ab, int c);
    logic [DB-1:0] v;
    v = '0;
    if (ab > 0 && c > ab) return v;
    for (int j = 0; j < W; j++) begin
      int m;
      m = c - 3 - j;
      if (m >= 0 && m < k) v[j*WD +: WD] = bmem[m][j*WD +: WD];
    end
    return v;
  endfunction

  // One tile: optional abort in cycle ab, optional stray start pulse in cycle st.
  task automatic test_tile(input int k, input logic [1:0] simd, input int ab,
                           input int st, input string tag);
    exp_t e;
    int   last;
    last = (k == 0) ? 1 : k + H + W + 2;
    start = 1'b1; k_len = AW'(k); simd_in = simd;
    @(posedge clk); #1;
    start = 1'b0; k_len = AW'($urandom); simd_in = 2'($urandom);
    for (int c = 1; c <= last + 2; c++) begin
      abort = (c == ab);
      start = (c == st);
      e = model_ctrl(k, ab, c);
      @(negedge clk);
      n_checks++;
      if ({busy, done, c_valid, arr_clear, a_rd_en, b_rd_en} !==
          {e.busy, e.done, e.done, e.clear, e.rd, e.rd})
        $display("FAIL %s ctrl c=%0d got %b exp %b", tag, c,
                 {busy, done, c_valid, arr_clear, a_rd_en, b_rd_en},
                 {e.busy, e.done, e.done, e.clear, e.rd, e.rd});
      else n_pass++;
      if (e.rd) begin
        n_checks++;
        if (a_rd_addr !== e.addr || b_rd_addr !== e.addr)
          $display("FAIL %s addr c=%0d got %0d/%0d exp %0d", tag, c, a_rd_addr, b_rd_addr, e.addr);
        else n_pass++;
      end
      n_checks++;
      if (arr_in_a !== model_a(k, ab, c))
        $display("FAIL %s arr_in_a c=%0d got %h exp %h", tag, c, arr_in_a, model_a(k, ab, c));
      else n_pass++;
      n_checks++;
      if (arr_in_b !== model_b(k, ab, c))
        $display("FAIL %s arr_in_b c=%0d got %h exp %h", tag, c, arr_in_b, model_b(k, ab, c));
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (arr_simd !== simd)
          $display("FAIL %s arr_simd c=%0d got %b exp %b", tag, c, arr_simd, simd);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; abort = 1'b0; k_len = '0; simd_in = 2'b00;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (outs !== '0) $display("FAIL reset_outs got %h exp 0", outs);
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, c_valid, arr_clear, a_rd_en, b_rd_en} !== 6'b0)
        $display("FAIL reset_idle got %b exp 000000",
                 {busy, done, c_valid, arr_clear, a_rd_en, b_rd_en});
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    fill_mem();
    test_tile(3, 2'b01, 0, 0, "basic_k3");
  endtask

  task automatic test_skew();
    fill_mem();
    amem[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    bmem[0] = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    test_tile(1, 2'b11, 0, 0, "skew_k1");
  endtask

  task automatic test_abort_feed();
    fill_mem();
    test_tile(3, 2'b10, 3, 0, "abort_feed");
  endtask

  task automatic test_start_in_drain();
    fill_mem();
    test_tile(3, 2'b01, 0, 7, "start_in_drain");
  endtask

  task automatic test_zero_len();
    test_tile(0, 2'b00, 0, 0, "zero_len");
  endtask

  task automatic test_abort_start_idle();
    abort = 1'b1; start = 1'b1; k_len = 8'd4; simd_in = 2'b11;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, a_rd_en, b_rd_en} !== 4'b0)
        $display("FAIL abort_start_idle got %b exp 0000", {busy, done, a_rd_en, b_rd_en});
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_feed();
    fill_mem();
    start = 1'b1; k_len = 8'd5; simd_in = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== '0) $display("FAIL reset_async got %h exp 0", outs);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (outs !== '0) $display("FAIL reset_hold got %h exp 0", outs);
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (H + W + 8) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, c_valid} !== 3'b0)
        $display("FAIL reset_abandon got %b exp 000", {busy, done, c_valid});
      else n_pass++;
      @(posedge clk); #1;
    end
    fill_mem();
    test_tile(2, 2'b10, 0, 0, "post_reset");
  endtask

  task automatic test_max_len();
    fill_mem();
    test_tile(255, 2'b11, 0, 0, "max_len");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int k, last, ab, st;
      k    = $urandom_range(12, 1);
      last = k + H + W + 2;
      ab   = ($urandom_range(2, 0) == 0) ? $urandom_range(last, 1) : 0;
      st   = ($urandom_range(1, 0) == 1) ? $urandom_range((ab > 0) ? ab : last, 1) : 0;
      fill_mem();
      test_tile(k, 2'($urandom), ab, st, "random");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    start = 1'b0; abort = 1'b0; k_len = '0; simd_in = 2'b00;
    fill_mem();
    test_reset();
    test_basic();
    test_skew();
    test_abort_feed();
    test_start_in_drain();
    test_zero_len();
    test_abort_start_idle();
    test_reset_mid_feed();
    test_max_len();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
